mdu_seq: RTL and testbench

MDU_SEQ -- requirements
Module: mdu_seq

---
 rtl/mdu_seq_pkg.sv | 39 +++
 rtl/mdu_seq_if.sv | 23 ++
 rtl/mdu_seq_calc.sv | 64 ++++++
 rtl/mdu_seq.sv | 111 +++++++++++
 tb/tb_mdu_seq.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/mdu_seq_pkg.sv
// Shared MDU definitions: op codes, latencies, FSM state codes and op-class helpers.
// The DIV state exists only when MDU_DIV_EN is defined.
package mdu_seq_pkg;

    localparam logic [3:0] MDU_NULL  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MFHI  = 4'd5;
    localparam logic [3:0] MDU_MFLO  = 4'd6;
    localparam logic [3:0] MDU_MTHI  = 4'd7;
    localparam logic [3:0] MDU_MTLO  = 4'd8;

    localparam int MDU_MUL_LAT = 5;
    localparam int MDU_DIV_LAT = 10;

    // Counter preload: the busy window ends on the edge where cnt is already 0.
    localparam logic [3:0] MUL_CNT_INIT = 4'(MDU_MUL_LAT - 1);
    localparam logic [3:0] DIV_CNT_INIT = 4'(MDU_DIV_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1
`ifdef MDU_DIV_EN
        ,
        ST_DIV  = 2'd2
`endif
    } mdu_state_e;

    function automatic logic is_mul(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// E-stage <-> MDU signal bundle; master is the pipeline, slave is the MDU.
interface mdu_seq_if;
    logic [3:0]  mdu_op;
    logic        start;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_md_use;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mdu_rdata;

    modport master (
        output mdu_op, start, rs_val, rt_val, d_md_use,
        input  busy, stall_req, hi, lo, mdu_rdata
    );

    modport slave (
        input  mdu_op, start, rs_val, rt_val, d_md_use,
        output busy, stall_req, hi, lo, mdu_rdata
    );
endinterface

// File: rtl/mdu_seq_calc.sv
// Combinational MDU arithmetic on latched operands: res = {HI, LO}; res_ok=0 blocks the write.
// Divider present only with MDU_DIV_EN; signed ops run on magnitudes then fix signs.
module mdu_calc
    import mdu_seq_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] res,
    output logic        res_ok
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

`ifdef MDU_DIV_EN
    logic        sgn;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quo;
    logic [31:0] rem;

    assign sgn   = (op == MDU_DIV);
    assign a_mag = (sgn && a[31]) ? (~a + 32'd1) : a;
    assign b_mag = (sgn && b[31]) ? (~b + 32'd1) : b;
    assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    // 0x80000000 / -1 wraps back to 0x80000000 through the negate.
    assign quo   = (sgn && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
    assign rem   = (sgn && a[31]) ? (~r_mag + 32'd1) : r_mag;
`endif

    always_comb begin
        res    = prod_u;
        res_ok = 1'b0;
        case (op)
            MDU_MULT: begin
                res    = prod_s;
                res_ok = 1'b1;
            end
            MDU_MULTU: begin
                res    = prod_u;
                res_ok = 1'b1;
            end
`ifdef MDU_DIV_EN
            MDU_DIV, MDU_DIVU: begin
                res    = {rem, quo};
                res_ok = (b != 32'd0);
            end
`endif
            default: begin
                res    = prod_u;
                res_ok = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mdu_seq.sv
// Multi-cycle MDU: mult 5 busy cycles, div/divu 10 (only with MDU_DIV_EN); HI/LO written on the final edge.
// Stalls D while an MDU instruction waits behind start/busy; start is ignored while busy.
module mdu_seq
    import mdu_seq_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    mdu_seq_if.slave   bus
);

    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  op_q;
    logic [31:0] rs_q;
    logic [31:0] rt_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        capture;
    logic        wr_res;
    logic [63:0] res;
    logic        res_ok;

    mdu_calc u_calc (
        .op     (op_q),
        .a      (rs_q),
        .b      (rt_q),
        .res    (res),
        .res_ok (res_ok)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        wr_res  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && is_mul(bus.mdu_op)) begin
                    state_d = ST_MUL;
                    cnt_d   = MUL_CNT_INIT;
                    capture = 1'b1;
                end
`ifdef MDU_DIV_EN
                else if (bus.start && is_div(bus.mdu_op)) begin
                    state_d = ST_DIV;
                    cnt_d   = DIV_CNT_INIT;
                    capture = 1'b1;
                end
`endif
            end
`ifdef MDU_DIV_EN
            ST_MUL, ST_DIV: begin
`else
            ST_MUL: begin
`endif
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                    wr_res  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q <= MDU_NULL;
            rs_q <= 32'd0;
            rt_q <= 32'd0;
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else begin
            if (capture) begin
                op_q <= bus.mdu_op;
                rs_q <= bus.rs_val;
                rt_q <= bus.rt_val;
            end
            // Divide-by-zero completes the busy window but leaves HI/LO alone.
            if (wr_res && res_ok) begin
                hi_q <= res[63:32];
                lo_q <= res[31:0];
            end else if (state_q == ST_IDLE) begin
                if (bus.mdu_op == MDU_MTHI) hi_q <= bus.rs_val;
                if (bus.mdu_op == MDU_MTLO) lo_q <= bus.rs_val;
            end
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.stall_req = ~reset & bus.d_md_use & (bus.busy | bus.start);
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.mdu_rdata = (bus.mdu_op == MDU_MFHI) ? hi_q :
                           (bus.mdu_op == MDU_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_seq.sv
// Bench for mdu_seq: vector table plus corner sequences; expected HI/LO queued at issue, popped at completion.
// Division expectations follow the MDU_DIV_EN setting of the build.
module tb_mdu_seq;
    import mdu_seq_pkg::*;

`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif
    localparam logic [31:0] PRI_HI = 32'hDEAD0001;
    localparam logic [31:0] PRI_LO = 32'hBEEF0002;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mdu_seq_if sif ();
    mdu_seq dut (.clk(clk), .reset(reset), .bus(sif.slave));

    int passed = 0;
    int total  = 0;

    typedef struct { logic [31:0] hi; logic [31:0] lo; } res_t;
    res_t sb[$];

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
        sif.mdu_op = MDU_MTHI; sif.rs_val = h; tick();
        sif.mdu_op = MDU_MTLO; sif.rs_val = l; tick();
        sif.mdu_op = MDU_NULL;
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int cyc);
        res_t r;
        int   n;
        r.hi = eh; r.lo = el;
        sb.push_back(r);
        sif.mdu_op = op; sif.rs_val = a; sif.rt_val = b; sif.start = 1'b1;
        tick();
        sif.start = 1'b0; sif.mdu_op = MDU_NULL;
        n = 0;
        while (sif.busy && n < 40) begin
            n++;
            tick();
        end
        chk($sformatf("%s busy_cycles", name), 32'(n), 32'(cyc));
        r = sb.pop_front();
        chk($sformatf("%s hi", name), sif.hi, r.hi);
        chk($sformatf("%s lo", name), sif.lo, r.lo);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, b, eh, el;
        longint          ps;
        longint unsigned pu;
        int              n;

        tbl[0]  = '{MDU_MULT,  32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        tbl[1]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, 5};
        tbl[2]  = '{MDU_MULT,  32'h7,        32'h6,        32'h0,        32'h2A,       5};
        tbl[3]  = '{MDU_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        5};
        tbl[4]  = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        tbl[5]  = '{MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h1,        5};
        tbl[6]  = '{MDU_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        tbl[7]  = '{MDU_DIVU,  32'h7,        32'h0,        PRI_HI,       PRI_LO,       10};
        tbl[8]  = '{MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 10};
        tbl[9]  = '{MDU_DIVU,  32'hFFFFFFF9, 32'h2,        32'h1,        32'h7FFFFFFC, 10};
        tbl[10] = '{MDU_DIV,   32'h7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 10};
        tbl[11] = '{MDU_DIV,   32'h0,        32'h0,        PRI_HI,       PRI_LO,       10};
        tbl[12] = '{MDU_NULL,  32'h5,        32'h5,        PRI_HI,       PRI_LO,       0};

        sif.mdu_op = MDU_NULL; sif.start = 1'b0; sif.rs_val = '0; sif.rt_val = '0;
        sif.d_md_use = 1'b0;
        reset = 1'b1;
        repeat (2) tick();
        chk("reset busy", 32'(sif.busy), 32'd0);
        chk("reset hi", sif.hi, 32'd0);
        chk("reset lo", sif.lo, 32'd0);
        sif.d_md_use = 1'b1; sif.start = 1'b1; sif.mdu_op = MDU_MULT;
        #1;
        chk("reset stall_req", 32'(sif.stall_req), 32'd0);
        sif.d_md_use = 1'b0; sif.start = 1'b0; sif.mdu_op = MDU_NULL;
        tick();
        reset = 1'b0;
        tick();
        chk("post-reset busy", 32'(sif.busy), 32'd0);

        for (int i = 0; i < 13; i++) begin
            vec_t v;
            v = tbl[i];
            if (is_div(v.op) && !DIV_EN) begin
                v.hi = PRI_HI; v.lo = PRI_LO; v.cyc = 0;
            end
            set_hilo(PRI_HI, PRI_LO);
            run_op($sformatf("vec%0d", i), v.op, v.a, v.b, v.hi, v.lo, v.cyc);
        end

        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom;
            if (i % 2 == 0) begin
                ps = longint'(int'(a)) * longint'(int'(b));
                eh = ps[63:32]; el = ps[31:0];
                run_op($sformatf("rnd_mult%0d", i), MDU_MULT, a, b, eh, el, 5);
            end else begin
                pu = longint'({32'd0, a}) * longint'({32'd0, b});
                eh = pu[63:32]; el = pu[31:0];
                run_op($sformatf("rnd_multu%0d", i), MDU_MULTU, a, b, eh, el, 5);
            end
        end

        // mf* read path and the zero default
        set_hilo(32'hFFFF0000, 32'h0000FFFF);
        sif.mdu_op = MDU_MFHI; #1;
        chk("rdata mfhi", sif.mdu_rdata, 32'hFFFF0000);
        sif.mdu_op = MDU_NULL; #1;
        chk("rdata null", sif.mdu_rdata, 32'd0);
        sif.start = 1'b1; sif.mdu_op = MDU_MFLO; #1;
        chk("stall needs d_md_use", 32'(sif.stall_req), 32'd0);
        sif.start = 1'b0; sif.mdu_op = MDU_NULL;

        // mflo waiting in D behind a mult
        sif.d_md_use = 1'b1; sif.mdu_op = MDU_MULT; sif.rs_val = 32'd3; sif.rt_val = 32'd5;
        sif.start = 1'b1;
        #1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!sif.stall_req) break;
            n++;
            tick();
            sif.start = 1'b0; sif.mdu_op = MDU_MFLO;
        end
        chk("stall cycles", 32'(n), 32'd6);
        chk("stall released", 32'(sif.stall_req), 32'd0);
        chk("stall rdata new lo", sif.mdu_rdata, 32'd15);
        sif.d_md_use = 1'b0; sif.mdu_op = MDU_NULL;

        // mthi while busy is dropped, a second start is ignored
        set_hilo(32'hCAFE0000, 32'h0);
        sif.mdu_op = MDU_MULT; sif.rs_val = 32'd3; sif.rt_val = 32'hFFFFFFFF; sif.start = 1'b1;
        tick();
        sif.start = 1'b0; sif.mdu_op = MDU_MTHI; sif.rs_val = 32'h12345678;
        tick();
        chk("mthi busy hi", sif.hi, 32'hCAFE0000);
        sif.mdu_op = MDU_MULTU; sif.rs_val = 32'd100; sif.rt_val = 32'd100; sif.start = 1'b1;
        tick();
        sif.start = 1'b0; sif.mdu_op = MDU_NULL;
        n = 2;
        while (sif.busy && n < 40) begin
            n++;
            tick();
        end
        chk("no restart cycles", 32'(n), 32'd5);
        chk("no restart hi", sif.hi, 32'hFFFFFFFF);
        chk("no restart lo", sif.lo, 32'hFFFFFFFD);
        sif.mdu_op = MDU_MTHI; sif.rs_val = 32'h12345678;
        tick();
        chk("mthi idle hi", sif.hi, 32'h12345678);
        sif.mdu_op = MDU_MTLO; sif.rs_val = 32'h87654321;
        tick();
        chk("mtlo idle lo", sif.lo, 32'h87654321);
        chk("mtlo keeps hi", sif.hi, 32'h12345678);
        sif.mdu_op = MDU_NULL;

        // reset in busy cycle 3 aborts the operation
        set_hilo(32'h11112222, 32'h33334444);
        sif.mdu_op = DIV_EN ? MDU_DIV : MDU_MULT;
        sif.rs_val = 32'hFFFFFFF9; sif.rt_val = 32'd2; sif.start = 1'b1;
        tick();
        sif.start = 1'b0; sif.mdu_op = MDU_NULL;
        tick();
        tick();
        chk("pre-reset busy", 32'(sif.busy), 32'd1);
        #1;
        reset = 1'b1;
        sif.start = 1'b1; sif.d_md_use = 1'b1; sif.mdu_op = MDU_MULT;
        #1;
        chk("abort busy", 32'(sif.busy), 32'd0);
        chk("abort hi", sif.hi, 32'd0);
        chk("abort lo", sif.lo, 32'd0);
        chk("abort stall_req", 32'(sif.stall_req), 32'd0);
        tick();
        sif.start = 1'b0; sif.d_md_use = 1'b0; sif.mdu_op = MDU_NULL;
        tick();
        reset = 1'b0;
        repeat (12) tick();
        chk("after abort busy", 32'(sif.busy), 32'd0);
        chk("after abort hi", sif.hi, 32'd0);
        chk("after abort lo", sif.lo, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
